// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: opcodes, funct fields, FSM states, ALU ops.
// decode_alu maps an opcode/funct pair onto the ALU op set, or ALU_NONE when unsupported.
package exec_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100, F3_SRL = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
    localparam logic [2:0] F3_MUL = 3'b000, F3_DIV = 3'b100, F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM = 3'b110, F3_REMU = 3'b111;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_NONE
    } alu_op_t;

    function automatic alu_op_t decode_alu(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7);
        alu_op_t op;
        op = ALU_NONE;
        if (opc == OP_R && f7 == F7_BASE) begin
            case (f3)
                F3_ADD:  op = ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SRL:  op = ALU_SRL;
                F3_OR:   op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end else if (opc == OP_R && f7 == F7_ALT) begin
            if (f3 == F3_ADD)      op = ALU_SUB;
            else if (f3 == F3_SRL) op = ALU_SRA;
        end else if (opc == OP_I) begin
            // funct7 is immediate bits here; only shifts constrain it (bit 0 is shamt[5] on RV64)
            case (f3)
                F3_ADD:  op = ALU_ADD;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_OR:   op = ALU_OR;
                F3_AND:  op = ALU_AND;
                F3_SLL:  if (f7[6:1] == F7_BASE[6:1]) op = ALU_SLL;
                default: begin
                    if (f7[6:1] == F7_BASE[6:1])     op = ALU_SRL;
                    else if (f7[6:1] == F7_ALT[6:1]) op = ALU_SRA;
                end
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV64I ALU op set with carry/overflow for ADD and SUB.
// For SUB, o_carry reports the borrow (set when A < B unsigned).
module alu_core
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_op_t         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_carry,
    output logic            o_overflow
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN:0]  w_sum;
    logic [XLEN:0]  w_diff;
    logic [SHW-1:0] w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result   = w_sum[XLEN-1:0];
                o_carry    = w_sum[XLEN];
                o_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
            end
            ALU_SUB: begin
                o_result   = w_diff[XLEN-1:0];
                o_carry    = w_diff[XLEN];
                o_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
            end
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative MUL/DIV/REM with
// valid/ready on both sides. MUL and DIV share the r_acc/r_sh register pair.
module exec_unit_mc
    import exec_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            alu_src,
    input  logic [XLEN-1:0] val_a,
    input  logic [XLEN-1:0] val_b,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            carry,
    output logic            overflow,
    output logic            zero_flag,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    state_t          r_state, w_state_nx;
    logic [XLEN-1:0] r_acc, r_sh, r_opnd, r_result;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic            r_carry, r_ovf, r_zero, r_is_rem, r_neg_q, r_neg_r, r_div0;

    logic [XLEN-1:0] w_b, w_a_mag, w_b_mag, w_alu_res, w_acc_nx, w_sh_nx, w_opnd_nx, w_fin;
    logic [XLEN:0]   w_trial, w_sub;
    logic            w_accept, w_is_mext, w_is_mul, w_is_div, w_div_signed, w_is_rem;
    logic            w_a_neg, w_b_neg, w_alu_c, w_alu_v, w_qbit;
    alu_op_t         w_alu_op;

    assign w_b       = alu_src ? imm : val_b;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_is_mext = (opcode == OP_R) && (funct7 == F7_MEXT);
    assign w_alu_op  = decode_alu(opcode, funct3, funct7);

    always_comb begin
        w_is_mul     = 1'b0;
        w_is_div     = 1'b0;
        w_div_signed = 1'b0;
        w_is_rem     = 1'b0;
        if (w_is_mext) begin
            case (funct3)
                F3_MUL:  w_is_mul = 1'b1;
                F3_DIV:  begin w_is_div = 1'b1; w_div_signed = 1'b1; end
                F3_DIVU: w_is_div = 1'b1;
                F3_REM:  begin w_is_div = 1'b1; w_div_signed = 1'b1; w_is_rem = 1'b1; end
                F3_REMU: begin w_is_div = 1'b1; w_is_rem = 1'b1; end
                default: ;
            endcase
        end
    end

    assign w_a_neg = w_div_signed && val_a[XLEN-1];
    assign w_b_neg = w_div_signed && w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -val_a : val_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    alu_core #(.XLEN(XLEN)) u_alu (
        .i_op      (w_alu_op),
        .i_a       (val_a),
        .i_b       (w_b),
        .o_result  (w_alu_res),
        .o_carry   (w_alu_c),
        .o_overflow(w_alu_v)
    );

    // Restoring divide: shift the next dividend bit into the partial remainder, try subtract.
    assign w_trial = {r_acc, r_sh[XLEN-1]};
    assign w_sub   = w_trial - {1'b0, r_opnd};
    assign w_qbit  = !w_sub[XLEN];

    always_comb begin
        w_acc_nx  = r_acc;
        w_sh_nx   = r_sh;
        w_opnd_nx = r_opnd;
        if (r_state == ST_MUL) begin
            for (int j = 0; j < MUL_STEP; j++)
                if (r_sh[j]) w_acc_nx = w_acc_nx + (r_opnd << j);
            w_opnd_nx = r_opnd << MUL_STEP;
            w_sh_nx   = r_sh >> MUL_STEP;
        end else begin
            w_acc_nx = w_qbit ? w_sub[XLEN-1:0] : w_trial[XLEN-1:0];
            w_sh_nx  = {r_sh[XLEN-2:0], w_qbit};
        end
    end

    // Sign fix-up on the last iteration; divide-by-zero quotient is forced to all ones.
    assign w_fin = (r_state == ST_MUL) ? w_acc_nx :
                   r_is_rem            ? (r_neg_r ? -w_acc_nx : w_acc_nx) :
                   r_div0              ? '1 :
                   r_neg_q             ? -w_sh_nx : w_sh_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)
                    w_state_nx = w_is_mul ? ST_MUL : (w_is_div ? ST_DIV : ST_DONE);
                ST_MUL, ST_DIV: if (r_cnt == '0) w_state_nx = ST_DONE;
                default: if (out_ready) w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sh     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rd     <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_rd     <= rd_in;
            r_acc    <= '0;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (w_b == '0);
            if (w_is_mul) begin
                r_sh   <= w_b;
                r_opnd <= val_a;
                r_cnt  <= MUL_LAST;
            end else if (w_is_div) begin
                r_sh   <= w_a_mag;
                r_opnd <= w_b_mag;
                r_cnt  <= DIV_LAST;
            end else begin
                r_result <= w_alu_res;
                r_carry  <= w_alu_c;
                r_ovf    <= w_alu_v;
                r_zero   <= (w_alu_res == '0);
            end
        end else if (r_state == ST_MUL || r_state == ST_DIV) begin
            r_acc  <= w_acc_nx;
            r_sh   <= w_sh_nx;
            r_opnd <= w_opnd_nx;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_result <= w_fin;
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_zero   <= (w_fin == '0);
            end
        end
    end

    assign result    = r_result;
    assign rd_out    = r_rd;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign zero_flag = r_zero;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc (XLEN=64, MUL_STEP=1): ALU, MUL, DIV/REM corners,
// backpressure, flush, mid-op reset and back-to-back throughput.
module tb_exec_unit_mc;
    import exec_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic        alu_src = 1'b0, out_ready = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] val_a = '0, val_b = '0, imm = '0;
    logic [4:0]  rd_in = '0;
    logic        in_ready, out_valid, carry, overflow, zero_flag, busy;
    logic [63:0] result;
    logic [4:0]  rd_out;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    exec_unit_mc #(.XLEN(64), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_src(alu_src),
        .val_a(val_a), .val_b(val_b), .imm(imm), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out),
        .carry(carry), .overflow(overflow), .zero_flag(zero_flag), .busy(busy)
    );

    typedef struct {
        logic [63:0] res; logic [4:0] rd; logic c; logic v; logic z; int lat;
    } exp_t;
    typedef struct {
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic src;
        logic [63:0] a; logic [63:0] b; logic [63:0] im; logic [63:0] res; logic c; logic v;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic src, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [4:0] rd);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        opcode = opc; funct3 = f3; funct7 = f7; alu_src = src;
        val_a = a; val_b = b; imm = im; rd_in = rd; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is seen; 200 means timeout.
    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 1; rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready || !busy) rdy_seen = 1'b1;
            @(posedge clk); #1 lat++;
        end
    endtask

    task automatic take();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({out_valid, result, rd_out, carry, overflow, zero_flag, busy} !== '0 || in_ready !== 1'b1)
            $display("FAIL reset_outputs got ov=%b res=%h rd=%0d c=%b v=%b z=%b busy=%b rdy=%b exp all 0, rdy=1",
                     out_valid, result, rd_out, carry, overflow, zero_flag, busy, in_ready);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        vec_t t[$]; exp_t e; int lat; bit rs;
        t.push_back('{OP_I, 3'b000, 7'h00, 1'b1, 64'd5, 64'd123, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        t.push_back('{OP_R, 3'b000, 7'h00, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, MIN, 1'b0, 1'b1});
        t.push_back('{OP_R, 3'b000, 7'h20, 1'b0, 64'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0});
        t.push_back('{OP_R, 3'b101, 7'h20, 1'b0, MIN, 64'd68, 64'd0, 64'hF800_0000_0000_0000, 1'b0, 1'b0});
        t.push_back('{OP_R, 3'b011, 7'h00, 1'b0, 64'd1, ONES, 64'd0, 64'd1, 1'b0, 1'b0});
        t.push_back('{OP_R, 3'b010, 7'h00, 1'b0, ONES, 64'd1, 64'd0, 64'd1, 1'b0, 1'b0});
        t.push_back('{OP_I, 3'b100, 7'h00, 1'b1, 64'hF0F0, 64'd0, 64'hFF, 64'hF00F, 1'b0, 1'b0});
        t.push_back('{OP_I, 3'b001, 7'h00, 1'b1, 64'd1, 64'd0, 64'd4, 64'd16, 1'b0, 1'b0});
        t.push_back('{7'b0110111, 3'b000, 7'h00, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 1'b0, 1'b0});
        t.push_back('{OP_R, 3'b001, 7'h01, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0, 1'b0, 1'b0});
        t.push_back('{OP_I, 3'b000, 7'h20, 1'b1, 64'd10, 64'd50, 64'd3, 64'd13, 1'b0, 1'b0});
        foreach (t[i]) begin
            sb.push_back('{t[i].res, 5'(i + 1), t[i].c, t[i].v, t[i].res == 64'd0, 1});
            issue(t[i].opc, t[i].f3, t[i].f7, t[i].src, t[i].a, t[i].b, t[i].im, 5'(i + 1));
            wait_out(lat, rs);
            e = sb.pop_front();
            n_chk++;
            if ({result, rd_out, carry, overflow, zero_flag} !== {e.res, e.rd, e.c, e.v, e.z})
                $display("FAIL alu[%0d] got res=%h rd=%0d c=%b v=%b z=%b exp res=%h rd=%0d c=%b v=%b z=%b",
                         i, result, rd_out, carry, overflow, zero_flag, e.res, e.rd, e.c, e.v, e.z);
            else n_pass++;
            n_chk++;
            if (lat !== e.lat) $display("FAIL alu_lat[%0d] got %0d exp %0d", i, lat, e.lat);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_mul();
        vec_t t[$]; exp_t e; int lat; bit rs;
        logic [63:0] x = 64'h1234_5678_9ABC_DEF0, y = 64'h0FED_CBA9_8765_4321, p;
        p = x * y;
        t.push_back('{OP_R, F3_MUL, F7_MEXT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_MUL, F7_MEXT, 1'b0, x, y, 64'd0, p, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_MUL, F7_MEXT, 1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0});
        foreach (t[i]) begin
            sb.push_back('{t[i].res, 5'(20 + i), 1'b0, 1'b0, t[i].res == 64'd0, 65});
            issue(t[i].opc, t[i].f3, t[i].f7, t[i].src, t[i].a, t[i].b, t[i].im, 5'(20 + i));
            wait_out(lat, rs);
            e = sb.pop_front();
            n_chk++;
            if ({result, rd_out, carry, overflow, zero_flag} !== {e.res, e.rd, e.c, e.v, e.z})
                $display("FAIL mul[%0d] got res=%h rd=%0d c=%b v=%b z=%b exp res=%h rd=%0d z=%b",
                         i, result, rd_out, carry, overflow, zero_flag, e.res, e.rd, e.z);
            else n_pass++;
            n_chk++;
            if (lat !== e.lat) $display("FAIL mul_lat[%0d] got %0d exp %0d", i, lat, e.lat);
            else n_pass++;
            n_chk++;
            if (rs !== 1'b0) $display("FAIL mul_busy[%0d] got in_ready/!busy seen=%b exp 0", i, rs);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_div();
        vec_t t[$]; exp_t e; int lat; bit rs;
        t.push_back('{OP_R, F3_DIV,  F7_MEXT, 1'b0, 64'd7, 64'd0, 64'd0, ONES, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_REM,  F7_MEXT, 1'b0, 64'd7, 64'd0, 64'd0, 64'd7, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_DIV,  F7_MEXT, 1'b0, MIN, ONES, 64'd0, MIN, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_REM,  F7_MEXT, 1'b0, MIN, ONES, 64'd0, 64'd0, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_DIV,  F7_MEXT, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_REM,  F7_MEXT, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, ONES, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_DIVU, F7_MEXT, 1'b0, 64'd100, 64'd7, 64'd0, 64'd14, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_REMU, F7_MEXT, 1'b0, ONES, 64'd10, 64'd0, 64'd5, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_DIV,  F7_MEXT, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'd0, ONES, 1'b0, 1'b0});
        t.push_back('{OP_R, F3_REM,  F7_MEXT, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0});
        foreach (t[i]) begin
            sb.push_back('{t[i].res, 5'(i), 1'b0, 1'b0, t[i].res == 64'd0, 65});
            issue(t[i].opc, t[i].f3, t[i].f7, t[i].src, t[i].a, t[i].b, t[i].im, 5'(i));
            wait_out(lat, rs);
            e = sb.pop_front();
            n_chk++;
            if ({result, rd_out, carry, overflow, zero_flag} !== {e.res, e.rd, e.c, e.v, e.z})
                $display("FAIL div[%0d] got res=%h rd=%0d c=%b v=%b z=%b exp res=%h rd=%0d z=%b",
                         i, result, rd_out, carry, overflow, zero_flag, e.res, e.rd, e.z);
            else n_pass++;
            n_chk++;
            if (lat !== e.lat) $display("FAIL div_lat[%0d] got %0d exp %0d", i, lat, e.lat);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_backpressure();
        exp_t e; int lat; bit rs; int bad = 0;
        sb.push_back('{64'd14, 5'd9, 1'b0, 1'b0, 1'b0, 65});
        issue(OP_R, F3_DIVU, F7_MEXT, 1'b0, 64'd100, 64'd7, 64'd0, 5'd9);
        wait_out(lat, rs);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            if (!out_valid || in_ready || result !== e.res || rd_out !== e.rd || zero_flag !== e.z) bad++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles exp 0 (res=%h exp %h)", bad, result, e.res);
        else n_pass++;
        take();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_single_transfer got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_flush_reset();
        exp_t e; int lat; bit rs; bit seen = 1'b0;
        issue(OP_R, F3_DIV, F7_MEXT, 1'b0, 64'd100, 64'd7, 64'd0, 5'd4);
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_div got rdy=%b ov=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
        else n_pass++;
        @(negedge clk);
        opcode = OP_R; funct3 = F3_ADD; funct7 = F7_BASE; alu_src = 1'b0;
        val_a = 64'd1; val_b = 64'd1; flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL flush_no_output got output/busy seen=%b exp 0", seen);
        else n_pass++;
        issue(OP_R, F3_MUL, F7_MEXT, 1'b0, 64'd3, 64'd3, 64'd0, 5'd6);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, result, rd_out, carry, overflow, zero_flag, busy} !== '0 || in_ready !== 1'b1)
            $display("FAIL reset_mid_mul got ov=%b busy=%b rdy=%b res=%h exp 0/0/1/0", out_valid, busy, in_ready, result);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL reset_no_output got out_valid seen=%b exp 0", seen);
        else n_pass++;
        sb.push_back('{64'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1});
        issue(OP_R, F3_ADD, F7_BASE, 1'b0, 64'd1, 64'd1, 64'd0, 5'd3);
        wait_out(lat, rs);
        e = sb.pop_front();
        n_chk++;
        if ({result, rd_out, zero_flag} !== {e.res, e.rd, e.z} || lat !== e.lat)
            $display("FAIL post_reset_add got res=%h rd=%0d lat=%0d exp res=%h rd=%0d lat=%0d",
                     result, rd_out, lat, e.res, e.rd, e.lat);
        else n_pass++;
        take();
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit rs; time t_prev = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{64'(10 * i + 5), 5'(i + 11), 1'b0, 1'b0, 1'b0, 1});
            issue(OP_R, F3_ADD, F7_BASE, 1'b0, 64'(10 * i), 64'd5, 64'd0, 5'(i + 11));
            wait_out(lat, rs);
            e = sb.pop_front();
            n_chk++;
            if (result !== e.res || rd_out !== e.rd || lat !== e.lat)
                $display("FAIL b2b[%0d] got res=%h rd=%0d lat=%0d exp res=%h rd=%0d lat=%0d",
                         i, result, rd_out, lat, e.res, e.rd, e.lat);
            else n_pass++;
            if (i > 0) begin
                n_chk++;
                if ($time - t_prev != 20) $display("FAIL b2b_rate[%0d] got %0t exp 20", i, $time - t_prev);
                else n_pass++;
            end
            t_prev = $time;
        end
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_backpressure();
        test_flush_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
